// File: rtl/puertas_actuador.sv
// puertas_actuador: car-side door mechanism driver.
// Takes the 2-bit door command, moves a travel-position counter, reports the
// 2-bit door status and the open-dwell timeout, and treats the light-curtain
// sensor as a hard reversal while closing.
module puertas_actuador #(
    parameter int T_TRAVEL = 8,   // cycles for a full stroke, 2..255
    parameter int T_OPEN   = 50,  // open-dwell cycles before timeout, 2..65535
    parameter int PW       = 8    // posicion width, 2**PW > T_TRAVEL
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    salida_puertas,
    input  logic          sensor,
    output logic [1:0]    puertas,
    output logic          timeout,
    output logic [PW-1:0] posicion,
    output logic [7:0]    reaperturas
);

    // The state encoding is the reported door status itself.
    localparam logic [1:0] CERRADA  = 2'b00;
    localparam logic [1:0] ABIERTA  = 2'b01;
    localparam logic [1:0] CERRANDO = 2'b10;
    localparam logic [1:0] ABRIENDO = 2'b11;

    localparam logic [PW-1:0] POS_MAX    = PW'(T_TRAVEL);
    localparam logic [PW-1:0] POS_ONE    = PW'(1);
    localparam logic [15:0]   DWELL_LAST = 16'(T_OPEN - 1);

    logic [1:0]    estado_q, estado_d;
    logic [PW-1:0] pos_q, pos_d;
    logic [15:0]   dwell_q, dwell_d;
    logic          timeout_q, timeout_d;
    logic [7:0]    reap_q, reap_d;

    // Command decode; 11 decodes to neither, so it behaves as 00.
    logic cmd_abrir, cmd_cerrar;
    assign cmd_abrir  = (salida_puertas == 2'b01);
    assign cmd_cerrar = (salida_puertas == 2'b10);

    // Next-state, position, dwell and reversal-count logic.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave one unassigned, which would otherwise infer a latch.
        estado_d  = estado_q;
        pos_d     = pos_q;
        dwell_d   = '0;       // dwell is held at 0 outside ABIERTA
        timeout_d = 1'b0;     // timeout is never 1 outside ABIERTA
        reap_d    = reap_q;

        case (estado_q)
            CERRADA: begin
                // Only an open command starts a stroke; the sensor alone does not.
                if (cmd_abrir) begin
                    estado_d = ABRIENDO;
                end
            end

            ABRIENDO: begin
                // The opening stroke always completes; close and sensor ignored.
                // The >= comparison keeps posicion from ever passing T_TRAVEL.
                if (pos_q >= POS_MAX - POS_ONE) begin
                    pos_d    = POS_MAX;
                    estado_d = ABIERTA;
                end else begin
                    pos_d = pos_q + POS_ONE;
                end
            end

            ABIERTA: begin
                if (cmd_cerrar && !sensor) begin
                    // Leaving: dwell and timeout fall back to their 0 defaults.
                    estado_d = CERRANDO;
                end else if (sensor || cmd_abrir) begin
                    // Obstruction or hold-open restarts the dwell (defaults clear it).
                    dwell_d   = '0;
                    timeout_d = 1'b0;
                end else if (dwell_q == DWELL_LAST) begin
                    dwell_d   = dwell_q;
                    timeout_d = 1'b1;
                end else begin
                    dwell_d = dwell_q + 16'd1;
                end
            end

            CERRANDO: begin
                if (sensor) begin
                    // Safety reversal has priority over any command.
                    estado_d = ABRIENDO;
                    if (reap_q != 8'hFF) begin
                        reap_d = reap_q + 8'd1;
                    end
                end else if (cmd_abrir) begin
                    estado_d = ABRIENDO;
                end else begin
                    pos_d = pos_q - POS_ONE;
                    if (pos_q == POS_ONE) begin
                        estado_d = CERRADA;
                    end
                end
            end

            default: begin
                estado_d = CERRADA;
            end
        endcase
    end

    // State registers; reset aborts any stroke and reports the door closed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q  <= CERRADA;
            pos_q     <= '0;
            dwell_q   <= '0;
            timeout_q <= 1'b0;
            reap_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            estado_q  <= estado_d;
            pos_q     <= pos_d;
            dwell_q   <= dwell_d;
            timeout_q <= timeout_d;
            reap_q    <= reap_d;
        end
    end

    assign puertas     = estado_q;
    assign posicion    = pos_q;
    assign timeout     = timeout_q;
    assign reaperturas = reap_q;

endmodule

// File: tb/tb_puertas_actuador.sv
// tb_puertas_actuador: directed scoreboard bench for puertas_actuador with
// T_TRAVEL=4, T_OPEN=6. The driver pushes the hand-computed post-edge
// outputs for every cycle it drives; a monitor pops and compares them.
module tb_puertas_actuador;

    localparam logic [1:0] CER = 2'b00;
    localparam logic [1:0] ABI = 2'b01;
    localparam logic [1:0] CRR = 2'b10;
    localparam logic [1:0] ABR = 2'b11;

    logic       clk;
    logic       rst_n;
    logic [1:0] salida_puertas;
    logic       sensor;
    logic [1:0] puertas;
    logic       timeout;
    logic [7:0] posicion;
    logic [7:0] reaperturas;

    puertas_actuador #(
        .T_TRAVEL(4),
        .T_OPEN  (6),
        .PW      (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .salida_puertas(salida_puertas),
        .sensor        (sensor),
        .puertas       (puertas),
        .timeout       (timeout),
        .posicion      (posicion),
        .reaperturas   (reaperturas)
    );

    // {puertas, posicion, timeout, reaperturas}
    typedef logic [18:0] snap_t;

    typedef struct {
        int    due;
        snap_t exp;
        string tag;
    } exp_t;

    exp_t       sb[$];
    int         cyc_cnt = 0;
    int         n_chk   = 0;
    int         n_pass  = 0;
    logic [7:0] e_reap  = 8'd0;
    string      cur_tag = "reset";

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic snap_t dut_snap();
        return {puertas, posicion, timeout, reaperturas};
    endfunction

    function automatic string fmt(input snap_t s);
        return $sformatf("puertas=%b posicion=%0d timeout=%b reaperturas=%0d",
                         s[18:17], s[16:9], s[8], s[7:0]);
    endfunction

    task automatic check(input string name, input snap_t got, input snap_t exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s (cycle %0d): got %s, expected %s",
                     name, cyc_cnt, fmt(got), fmt(exp));
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input logic [1:0] cmd, input logic s,
                        input logic [1:0] ep, input int epos, input logic et);
        exp_t e;
        salida_puertas = cmd;
        sensor         = s;
        e.due = cyc_cnt + 1;
        e.exp = {ep, 8'(epos), et, e_reap};
        e.tag = cur_tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Full opening stroke from CERRADA: 4 cycles in ABRIENDO at 0,1,2,3.
    task automatic open_full();
        step(2'b01, 1'b0, ABR, 0, 1'b0);
        for (int p = 1; p <= 3; p++) step(2'b00, 1'b0, ABR, p, 1'b0);
        step(2'b00, 1'b0, ABI, 4, 1'b0);
    endtask

    // Full closing stroke from ABIERTA.
    task automatic close_full();
        step(2'b10, 1'b0, CRR, 4, 1'b0);
        step(2'b00, 1'b0, CRR, 3, 1'b0);
        step(2'b00, 1'b0, CRR, 2, 1'b0);
        step(2'b00, 1'b0, CRR, 1, 1'b0);
        step(2'b00, 1'b0, CER, 0, 1'b0);
    endtask

    // Monitor: after each edge, compare every expectation due this cycle.
    initial begin
        forever begin
            @(posedge clk);
            cyc_cnt++;
            #2;
            while (sb.size() > 0 && sb[0].due <= cyc_cnt) begin
                exp_t e;
                e = sb.pop_front();
                check(e.tag, dut_snap(), e.exp);
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
                 n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    // Stimulus.
    initial begin
        rst_n          = 1'b0;
        salida_puertas = 2'b00;
        sensor         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", dut_snap(), 19'd0);
        rst_n = 1'b1;

        // Open stroke, then dwell timeout 6 cycles after puertas reads 01.
        cur_tag = "open_stroke";
        open_full();
        cur_tag = "dwell";
        for (int i = 0; i < 5; i++) step(2'b00, 1'b0, ABI, 4, 1'b0);
        step(2'b00, 1'b0, ABI, 4, 1'b1);
        step(2'b00, 1'b0, ABI, 4, 1'b1);
        cur_tag = "close_stroke";
        close_full();

        // CERRADA ignores none, 11 and the sensor alone.
        cur_tag = "closed_hold";
        step(2'b00, 1'b0, CER, 0, 1'b0);
        step(2'b11, 1'b0, CER, 0, 1'b0);
        step(2'b00, 1'b1, CER, 0, 1'b0);
        step(2'b11, 1'b1, CER, 0, 1'b0);

        // Sensor pulse while closing at posicion 2.
        cur_tag = "sensor_reversal";
        open_full();
        step(2'b10, 1'b0, CRR, 4, 1'b0);
        step(2'b00, 1'b0, CRR, 3, 1'b0);
        step(2'b00, 1'b0, CRR, 2, 1'b0);
        e_reap = 8'd1;
        step(2'b00, 1'b1, ABR, 2, 1'b0);
        step(2'b00, 1'b0, ABR, 3, 1'b0);
        step(2'b00, 1'b0, ABI, 4, 1'b0);

        // Open command while closing reverses without counting.
        cur_tag = "cmd_reversal";
        step(2'b10, 1'b0, CRR, 4, 1'b0);
        step(2'b00, 1'b0, CRR, 3, 1'b0);
        step(2'b01, 1'b0, ABR, 3, 1'b0);
        step(2'b00, 1'b0, ABI, 4, 1'b0);

        // Sensor wins over a simultaneous close command.
        cur_tag = "sensor_priority";
        step(2'b10, 1'b0, CRR, 4, 1'b0);
        step(2'b00, 1'b0, CRR, 3, 1'b0);
        e_reap = 8'd2;
        step(2'b10, 1'b1, ABR, 3, 1'b0);
        step(2'b00, 1'b0, ABI, 4, 1'b0);

        // Close refused while obstructed; dwell restarts when sensor drops.
        cur_tag = "close_refused";
        for (int i = 0; i < 10; i++) step(2'b10, 1'b1, ABI, 4, 1'b0);
        cur_tag = "dwell_after_sensor";
        for (int i = 0; i < 5; i++) step(2'b00, 1'b0, ABI, 4, 1'b0);
        step(2'b00, 1'b0, ABI, 4, 1'b1);
        cur_tag = "hold_open_clears";
        step(2'b01, 1'b0, ABI, 4, 1'b0);
        step(2'b00, 1'b0, ABI, 4, 1'b0);
        cur_tag = "close_after_dwell";
        close_full();

        // Close command during opening is ignored.
        cur_tag = "close_while_opening";
        step(2'b01, 1'b0, ABR, 0, 1'b0);
        step(2'b00, 1'b0, ABR, 1, 1'b0);
        step(2'b10, 1'b0, ABR, 2, 1'b0);
        step(2'b10, 1'b1, ABR, 3, 1'b0);
        step(2'b10, 1'b0, ABI, 4, 1'b0);

        // Asynchronous reset mid-close at posicion 3.
        cur_tag = "pre_reset_close";
        step(2'b10, 1'b0, CRR, 4, 1'b0);
        step(2'b00, 1'b0, CRR, 3, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_mid_close", dut_snap(), 19'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        e_reap  = 8'd0;
        cur_tag = "after_reset";
        step(2'b00, 1'b0, CER, 0, 1'b0);

        // 300 forced reversals: reaperturas saturates at 255.
        cur_tag = "saturate_open";
        open_full();
        cur_tag = "saturate";
        for (int i = 1; i <= 300; i++) begin
            step(2'b10, 1'b0, CRR, 4, 1'b0);
            step(2'b00, 1'b0, CRR, 3, 1'b0);
            e_reap = (i > 255) ? 8'd255 : 8'(i);
            step(2'b00, 1'b1, ABR, 3, 1'b0);
            step(2'b00, 1'b0, ABI, 4, 1'b0);
        end
        check("reaperturas_saturated", {puertas, posicion, timeout, reaperturas},
              {ABI, 8'd4, 1'b0, 8'd255});

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 5 && sb.size() > 0; i++) begin
            @(posedge clk);
            #3;
        end
        n_chk++;
        if (sb.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/puertas_actuador.md
Name: puertas_actuador

Overview:
- Door mechanism model/driver on the car side of the door command interface.
- Accepts the 2-bit door command from the door controller and runs a travel-position counter.
- Reports the 2-bit door status back to the controller, plus the open-dwell timeout.
- Enforces the light-curtain sensor as a hard safety reversal, independent of the command.

Parameters:
T_TRAVEL, 8, cycles for a full open or full close stroke (legal range 2..255).
T_OPEN, 50, cycles the door stays fully open without a close before timeout asserts (legal range 2..65535).
PW, 8, width of the posicion output; must satisfy 2^PW > T_TRAVEL.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
salida_puertas  in  2  door command: 01 open, 10 close, 00 none. 11 is treated as 00.
sensor  in  1  1 = obstruction between the doors.
puertas  out  2  door status: 00 fully closed, 01 fully open, 10 closing, 11 opening.
timeout  out  1  level signal; 1 = open dwell expired.
posicion  out  PW  door travel position: 0 = closed, T_TRAVEL = fully open.
reaperturas  out  8  saturating count of sensor-forced reversals.

Behaviour:
- Reset is asynchronous, active-low. While rst_n = 0:
  - puertas = 00, posicion = 0, timeout = 0, reaperturas = 0.
  - Internal dwell counter = 0.
  - Reset asserted mid-stroke aborts the stroke immediately; on release the door is reported CERRADA.
- All outputs are registered. Inputs are sampled on posedge clk. A status change is visible the cycle after the sampling edge.
- State machine: the state encoding is puertas itself.
- CERRADA (00):
  - cmd 01 -> ABRIENDO; posicion stays 0 on this edge.
  - Otherwise stay. The sensor alone does not open the door.
- ABRIENDO (11):
  - Every edge: posicion + 1.
  - On the edge where posicion becomes T_TRAVEL -> ABIERTA.
  - A full stroke from 0 spends exactly T_TRAVEL cycles in ABRIENDO.
  - cmd 10 and sensor are ignored; the opening stroke always completes.
- ABIERTA (01):
  - cmd 10 and sensor = 0 -> CERRANDO; posicion stays T_TRAVEL on this edge.
  - cmd 10 and sensor = 1 -> stay; the close is refused.
- CERRANDO (10):
  - If sensor = 1 -> ABRIENDO from the current posicion (no decrement on this edge), and reaperturas increments (saturates at 255). Sensor takes priority over any command.
  - Else if cmd 01 -> ABRIENDO from the current posicion; reaperturas is unchanged.
  - Else posicion - 1 each edge; on the edge where posicion becomes 0 -> CERRADA.
  - A reversal at position p needs T_TRAVEL - p cycles in ABRIENDO to reach ABIERTA.
- Dwell/timeout:
  - The dwell counter is 16 bits. It is 0 on entry to ABIERTA and is held at 0 in every other state.
  - In ABIERTA with sensor = 1 or cmd 01: counter cleared, timeout <= 0 (hold-open / obstruction restarts the dwell).
  - Otherwise in ABIERTA: if counter == T_OPEN - 1, timeout <= 1 and holds; else counter + 1.
  - Net effect: timeout rises T_OPEN cycles after puertas first reads 01, provided there is no sensor and no cmd 01.
  - timeout clears on the same edge that leaves ABIERTA. It is never 1 outside ABIERTA.
- Invariants:
  - posicion is 0 in CERRADA and T_TRAVEL in ABIERTA.
  - posicion is strictly between 0 and T_TRAVEL in ABRIENDO/CERRANDO, except on the first cycle after a transition.
  - posicion never wraps.
- cmd 11 is treated as 00 in all states. No other illegal input combinations exist.

Test Plan:
- All tests use T_TRAVEL=4, T_OPEN=6.
- Reset then cmd 01 for 1 cycle -> puertas 11 next cycle; posicion 1,2,3,4 on following edges; puertas 01 when posicion=4; timeout=0.
- Door open, cmd 00, sensor 0 -> timeout rises exactly 6 cycles after puertas=01. Then cmd 10 -> puertas 10 and timeout 0 next cycle; posicion 3,2,1,0; puertas 00.
- Closing at posicion 2, sensor pulse 1 cycle -> puertas 11 with posicion 2 next cycle; reaperturas 0->1; ABIERTA after 2 more cycles.
- Open, sensor held high for 10 cycles with cmd 10 -> puertas stays 01, timeout stays 0. Sensor drops -> timeout 6 cycles later. Then cmd 10 -> closes.
- Opening at posicion 1, cmd 10 -> opening completes to posicion 4, puertas 01. Separately, cmd 11 in CERRADA -> stays 00.
- rst_n low mid-close at posicion 3 -> outputs 0 immediately, asynchronous. Also: 300 forced reversals -> reaperturas saturates at 255.
